pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central sequencing controller for the non-forwarding 5-stage RV32I pipeline (IF, ID, EX, MEM, WB). Tracks in-flight destination registers in a shadow pipe and generates every pipeline-register enable/flush. Detects RAW hazards (stall, no forwarding), applies taken-branch/jump redirect flushes and LSU freezes, and drains to a halt on the end-of-program marker. Exposes cycle, retired-instruction, control-transfer and redirect counters for performance analysis.

## Interface
- HALT_INSN, 32'h1111_1111, end-of-program marker word recognised in ID
- CNT_W, 32, width of each performance counter
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_id_vld  in  1  ID stage holds a valid instruction
- i_id_instr  in  32  instruction word in ID
- i_mem_redirect  in  1  branch/jump in MEM resolved taken (PC select)
- i_mem_is_ctrl  in  1  instruction in MEM is a branch or jump
- i_mem_stall  in  1  LSU not ready; freeze whole pipeline
- o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en  out  1 each  pipeline-register load enables
- o_ifid_flush, o_idex_flush, o_exmem_flush  out  1 each  load bubble into that register (priority over enable)
- o_insn_vld  out  1  valid instruction retires from WB this cycle
- o_halted  out  1  pipeline drained after halt marker
- o_cnt_cycle, o_cnt_retired, o_cnt_ctrl, o_cnt_redirect  out  CNT_W each  performance counters

## Operation
- Shadow pipe: three entries EX/MEM/WB, each {vld, wr, rd[4:0]}; rd/wr/rs-usage decoded from i_id_instr opcode (R, I-ALU, LOAD, JALR, JAL, LUI, AUIPC write rd; R, I, LOAD, STORE, BRANCH, JALR read rs1; R, STORE, BRANCH read rs2). rd=x0 never counts as a writer.
- RAW hazard: i_id_vld and a used rs (≠x0) equals rd of any vld&wr entry including WB (regfile has no write-through).
- Per-cycle priority: i_mem_stall > i_mem_redirect > RAW > halt detect > normal.
  - Mem stall: all enables 0, all flushes 0, shadow holds.
  - Redirect: all enables 1; ifid, idex, exmem flush = 1; shadow WB←MEM, MEM←bubble, EX←bubble.
  - RAW: pc_en=ifid_en=0, idex_flush=1, other enables 1; shadow EX←bubble, MEM←EX, WB←MEM.
  - Normal: all enables 1, no flush; shadow EX←decoded ID, MEM←EX, WB←MEM.
- FSM states BOOT, RUN, DRAIN, HALTED.
  - BOOT: one cycle; pc_en=0, all three flushes 1, shadow cleared; → RUN.
  - RUN: normal policy; HALT_INSN valid in ID with no stall/redirect/RAW → DRAIN; that cycle pc_en=ifid_en=0, idex_flush=1 (marker never enters EX).
  - DRAIN: pc_en=ifid_en=0, idex_flush=1 every cycle; EX/MEM/WB advance per priority. i_mem_redirect → RUN (marker was wrong-path) with redirect flush. All shadow vld=0 → HALTED.
  - HALTED: all enables 0, flushes 0, o_halted=1; left only by reset.
- o_insn_vld = WB.vld & ~i_mem_stall & state∈{RUN,DRAIN}.
- Counters: cycle +1 each RUN/DRAIN cycle (including stalls); retired +1 on o_insn_vld; ctrl +1 when i_mem_is_ctrl & ~i_mem_stall; redirect +1 when i_mem_redirect & ~i_mem_stall. All wrap modulo 2^CNT_W; frozen in BOOT/HALTED.

## Timing
- Reset: while i_rst=1 outputs take BOOT values (pc_en=0, ifid/idex/exmem flush=1, other enables 0, o_insn_vld=0, o_halted=0); next edge state=BOOT, shadow empty, counters 0. Reset mid-DRAIN/HALTED returns to BOOT identically.
- Enables/flushes combinational from state, shadow and inputs; same cycle as cause.
- RAW stall length: producer in EX 3 cycles, MEM 2, WB 1; back-to-back dependent pair costs 3 bubbles.
- Redirect penalty: 3 bubbles; redirect and RAW in same cycle → redirect only, no stall.
- Redirect during mem stall deferred (EX/MEM frozen, input stays high) until stall drops; counted once.
- HALTED asserted the cycle after the last valid shadow entry leaves WB.

## Structure
- Package pipe_ctrl_pkg: state enum, RV32I opcode constants, shadow-entry struct, decode function returning {wr, rd, rs1_use, rs1, rs2_use, rs2}.
- Sub-module pipe_ctrl_shadow: 3-entry shadow pipe with hold/bubble/advance controls and hazard compare; FSM and counters stay in pipe_ctrl.

## Test plan
- Reset, then addi x1,x0,5 followed by add x2,x1,x1 → 3 cycles idex_flush=1, pc_en=0; then add advances; retired counts 2.
- Dependency through x0 (addi x0,x0,1; add x3,x0,x0) → no stall.
- beq taken: assert i_mem_redirect 1 cycle → three flushes same cycle; ctrl=1, redirect=1.
- i_mem_stall held 4 cycles with i_mem_redirect high → all enables 0 for 4 cycles, flush on 5th, redirect counter +1 only.
- HALT_INSN in ID with two ALU ops ahead → DRAIN 2 cycles then o_halted=1; counters frozen thereafter.
- HALT_INSN in ID, redirect next cycle → back to RUN, marker flushed, fetch resumes at pc_en=1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and helpers for the 5-stage pipeline controller.
//   state_t        controller FSM states
//   shadow_op_t    per-cycle update command for the shadow destination pipe
//   shadow_entry_t one in-flight instruction slot {vld, wr, rd}
//   decode_t       register usage extracted from an instruction word
//   decode_instr() opcode-based register usage decode (RV32I)
package pipe_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        SH_HOLD     = 3'd0,
        SH_CLEAR    = 3'd1,
        SH_ADVANCE  = 3'd2,
        SH_BUBBLE   = 3'd3,
        SH_REDIRECT = 3'd4
    } shadow_op_t;

    typedef struct packed {
        logic       vld;
        logic       wr;
        logic [4:0] rd;
    } shadow_entry_t;

    typedef struct packed {
        logic       wr;
        logic [4:0] rd;
        logic       rs1_use;
        logic [4:0] rs1;
        logic       rs2_use;
        logic [4:0] rs2;
    } decode_t;

    function automatic decode_t decode_instr(input logic [31:0] instr);
        decode_t d;
        d.rd      = instr[11:7];
        d.rs1     = instr[19:15];
        d.rs2     = instr[24:20];
        d.wr      = 1'b0;
        d.rs1_use = 1'b0;
        d.rs2_use = 1'b0;
        case (instr[6:0])
            OP_R: begin
                d.wr      = 1'b1;
                d.rs1_use = 1'b1;
                d.rs2_use = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                d.wr      = 1'b1;
                d.rs1_use = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                d.rs1_use = 1'b1;
                d.rs2_use = 1'b1;
            end
            OP_JAL, OP_LUI, OP_AUIPC: begin
                d.wr = 1'b1;
            end
            default: ;
        endcase
        // x0 is hardwired zero, so writing it can never create a dependency
        if (d.rd == 5'd0) begin
            d.wr = 1'b0;
        end
        return d;
    endfunction

endpackage

// File: rtl/pipe_ctrl_shadow.sv
// pipe_ctrl_shadow: three-entry shadow of the EX/MEM/WB destination registers.
//   clk, rst        clock, synchronous active-high reset (empties the pipe)
//   op              update command for this cycle (hold/clear/advance/bubble/redirect)
//   id_entry        entry loaded into EX on an advance
//   rs1_use/rs1     first source operand of the instruction in ID
//   rs2_use/rs2     second source operand of the instruction in ID
//   raw             a used, non-x0 source matches a pending writer in EX, MEM or WB
//   ex_vld/mem_vld/wb_vld  slot occupancy
module pipe_ctrl_shadow
    import pipe_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  shadow_op_t    op,
    input  shadow_entry_t id_entry,
    input  logic          rs1_use,
    input  logic [4:0]    rs1,
    input  logic          rs2_use,
    input  logic [4:0]    rs2,
    output logic          raw,
    output logic          ex_vld,
    output logic          mem_vld,
    output logic          wb_vld
);

    shadow_entry_t ex_q, mem_q, wb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            case (op)
                SH_CLEAR: begin
                    ex_q  <= '0;
                    mem_q <= '0;
                    wb_q  <= '0;
                end
                SH_ADVANCE: begin
                    ex_q  <= id_entry;
                    mem_q <= ex_q;
                    wb_q  <= mem_q;
                end
                SH_BUBBLE: begin
                    ex_q  <= '0;
                    mem_q <= ex_q;
                    wb_q  <= mem_q;
                end
                SH_REDIRECT: begin
                    ex_q  <= '0;
                    mem_q <= '0;
                    wb_q  <= mem_q;
                end
                default: ;
            endcase
        end
    end

    function automatic logic hit(input shadow_entry_t e, input logic [4:0] rs);
        return e.vld & e.wr & (e.rd == rs);
    endfunction

    // WB is included: the register file has no write-through path
    logic rs1_hit, rs2_hit;
    always_comb begin
        rs1_hit = rs1_use & (rs1 != 5'd0) & (hit(ex_q, rs1) | hit(mem_q, rs1) | hit(wb_q, rs1));
        rs2_hit = rs2_use & (rs2 != 5'd0) & (hit(ex_q, rs2) | hit(mem_q, rs2) | hit(wb_q, rs2));
    end

    assign raw     = rs1_hit | rs2_hit;
    assign ex_vld  = ex_q.vld;
    assign mem_vld = mem_q.vld;
    assign wb_vld  = wb_q.vld;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: sequencing controller for a non-forwarding 5-stage RV32I pipeline.
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_id_vld, i_id_instr             instruction currently in ID
//   i_mem_redirect, i_mem_is_ctrl    taken control transfer / control insn in MEM
//   i_mem_stall                      LSU not ready, freeze everything
//   o_*_en                           pipeline-register load enables
//   o_*_flush                        load a bubble (wins over the enable)
//   o_insn_vld, o_halted             retire strobe, drained-after-halt flag
//   o_cnt_*                          cycle / retired / control / redirect counters
//
// state   | meaning
// BOOT    | one cycle after reset: flush front end, clear shadow
// RUN     | normal issue with RAW stalls and redirects
// DRAIN   | halt marker seen; no new issue, let EX/MEM/WB empty
// HALTED  | pipeline empty, everything frozen until reset
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] HALT_INSN = 32'h1111_1111,
    parameter int          CNT_W     = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_id_vld,
    input  logic [31:0]      i_id_instr,
    input  logic             i_mem_redirect,
    input  logic             i_mem_is_ctrl,
    input  logic             i_mem_stall,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_idex_en,
    output logic             o_exmem_en,
    output logic             o_memwb_en,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_exmem_flush,
    output logic             o_insn_vld,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_cnt_cycle,
    output logic [CNT_W-1:0] o_cnt_retired,
    output logic [CNT_W-1:0] o_cnt_ctrl,
    output logic [CNT_W-1:0] o_cnt_redirect
);

    state_t        state, state_nxt;
    shadow_op_t    sh_op;
    decode_t       dec;
    shadow_entry_t id_entry;
    logic          sh_raw, ex_vld, mem_vld, wb_vld;
    logic          raw, is_halt, active;

    always_comb begin
        dec      = decode_instr(i_id_instr);
        id_entry = '{vld: i_id_vld, wr: dec.wr, rd: dec.rd};
    end

    pipe_ctrl_shadow u_shadow (
        .clk      (i_clk),
        .rst      (i_rst),
        .op       (sh_op),
        .id_entry (id_entry),
        .rs1_use  (dec.rs1_use),
        .rs1      (dec.rs1),
        .rs2_use  (dec.rs2_use),
        .rs2      (dec.rs2),
        .raw      (sh_raw),
        .ex_vld   (ex_vld),
        .mem_vld  (mem_vld),
        .wb_vld   (wb_vld)
    );

    assign raw     = i_id_vld & sh_raw;
    assign is_halt = i_id_vld & (i_id_instr == HALT_INSN);
    assign active  = (state == ST_RUN) || (state == ST_DRAIN);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        sh_op         = SH_HOLD;
        o_pc_en       = 1'b0;
        o_ifid_en     = 1'b0;
        o_idex_en     = 1'b0;
        o_exmem_en    = 1'b0;
        o_memwb_en    = 1'b0;
        o_ifid_flush  = 1'b0;
        o_idex_flush  = 1'b0;
        o_exmem_flush = 1'b0;
        o_halted      = 1'b0;
        if (i_rst) begin
            // BOOT values are presented while reset is held, before state is known
            o_ifid_flush  = 1'b1;
            o_idex_flush  = 1'b1;
            o_exmem_flush = 1'b1;
        end else begin
            case (state)
                ST_BOOT: begin
                    o_ifid_flush  = 1'b1;
                    o_idex_flush  = 1'b1;
                    o_exmem_flush = 1'b1;
                    sh_op         = SH_CLEAR;
                    state_nxt     = ST_RUN;
                end
                ST_RUN, ST_DRAIN: begin
                    if (i_mem_stall) begin
                        sh_op = SH_HOLD;
                    end else if (i_mem_redirect) begin
                        o_pc_en       = 1'b1;
                        o_ifid_en     = 1'b1;
                        o_idex_en     = 1'b1;
                        o_exmem_en    = 1'b1;
                        o_memwb_en    = 1'b1;
                        o_ifid_flush  = 1'b1;
                        o_idex_flush  = 1'b1;
                        o_exmem_flush = 1'b1;
                        sh_op         = SH_REDIRECT;
                        // a halt marker seen in DRAIN was on the wrong path
                        state_nxt     = ST_RUN;
                    end else if ((state == ST_DRAIN) || raw || is_halt) begin
                        o_idex_en    = 1'b1;
                        o_exmem_en   = 1'b1;
                        o_memwb_en   = 1'b1;
                        o_idex_flush = 1'b1;
                        sh_op        = SH_BUBBLE;
                        if ((state == ST_RUN) && !raw && is_halt) begin
                            state_nxt = ST_DRAIN;
                        end
                        // WB leaves this cycle, so empty EX/MEM means empty next cycle
                        if ((state == ST_DRAIN) && !ex_vld && !mem_vld) begin
                            state_nxt = ST_HALTED;
                        end
                    end else begin
                        o_pc_en    = 1'b1;
                        o_ifid_en  = 1'b1;
                        o_idex_en  = 1'b1;
                        o_exmem_en = 1'b1;
                        o_memwb_en = 1'b1;
                        sh_op      = SH_ADVANCE;
                    end
                end
                ST_HALTED: begin
                    o_halted = 1'b1;
                end
                default: state_nxt = ST_BOOT;
            endcase
        end
    end

    assign o_insn_vld = wb_vld & ~i_mem_stall & active & ~i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_cnt_cycle    <= '0;
            o_cnt_retired  <= '0;
            o_cnt_ctrl     <= '0;
            o_cnt_redirect <= '0;
        end else if (active) begin
            o_cnt_cycle <= o_cnt_cycle + CNT_W'(1);
            if (o_insn_vld) begin
                o_cnt_retired <= o_cnt_retired + CNT_W'(1);
            end
            if (i_mem_is_ctrl && !i_mem_stall) begin
                o_cnt_ctrl <= o_cnt_ctrl + CNT_W'(1);
            end
            if (i_mem_redirect && !i_mem_stall) begin
                o_cnt_redirect <= o_cnt_redirect + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    localparam logic [31:0] HALT    = 32'h1111_1111;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] ADDI_X1 = 32'h0050_0093;  // addi x1,x0,5
    localparam logic [31:0] ADDI_X2 = 32'h0070_0113;  // addi x2,x0,7
    localparam logic [31:0] ADD_X2  = 32'h0010_8133;  // add x2,x1,x1
    localparam logic [31:0] ADDI_X0 = 32'h0010_0013;  // addi x0,x0,1
    localparam logic [31:0] ADD_X3  = 32'h0000_01B3;  // add x3,x0,x0
    localparam logic [31:0] BEQ     = 32'h0000_0063;  // beq x0,x0

    // {pc, ifid, idex, exmem, memwb enables, ifid, idex, exmem flushes}
    localparam logic [7:0] C_BOOT   = 8'b00000_111;
    localparam logic [7:0] C_NORM   = 8'b11111_000;
    localparam logic [7:0] C_HOLD   = 8'b00111_010;
    localparam logic [7:0] C_REDIR  = 8'b11111_111;
    localparam logic [7:0] C_FREEZE = 8'b00000_000;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_vld;
    logic [31:0] id_instr;
    logic        redir, is_ctrl, stall;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_fl, idex_fl, exmem_fl, insn_vld, halted;
    logic [31:0] cnt_cycle, cnt_retired, cnt_ctrl, cnt_redirect;
    logic [7:0]  code;

    assign code = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl};

    pipe_ctrl #(.HALT_INSN(32'h1111_1111), .CNT_W(32)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_id_vld       (id_vld),
        .i_id_instr     (id_instr),
        .i_mem_redirect (redir),
        .i_mem_is_ctrl  (is_ctrl),
        .i_mem_stall    (stall),
        .o_pc_en        (pc_en),
        .o_ifid_en      (ifid_en),
        .o_idex_en      (idex_en),
        .o_exmem_en     (exmem_en),
        .o_memwb_en     (memwb_en),
        .o_ifid_flush   (ifid_fl),
        .o_idex_flush   (idex_fl),
        .o_exmem_flush  (exmem_fl),
        .o_insn_vld     (insn_vld),
        .o_halted       (halted),
        .o_cnt_cycle    (cnt_cycle),
        .o_cnt_retired  (cnt_retired),
        .o_cnt_ctrl     (cnt_ctrl),
        .o_cnt_redirect (cnt_redirect)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic v, input logic [31:0] w, input logic r,
                          input logic c, input logic s);
        id_vld   = v;
        id_instr = w;
        redir    = r;
        is_ctrl  = c;
        stall    = s;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag, input int cyc, input int ret,
                           input int ctl, input int rdr);
        chk({tag, " cnt_cycle"}, cnt_cycle, cyc);
        chk({tag, " cnt_retired"}, cnt_retired, ret);
        chk({tag, " cnt_ctrl"}, cnt_ctrl, ctl);
        chk({tag, " cnt_redirect"}, cnt_redirect, rdr);
    endtask

    // Leaves the DUT at the start of its first RUN cycle
    task automatic do_reset();
        set_in(1'b0, NOP, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("boot code", code, C_BOOT);
        step();
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int stage;  // 1=EX 2=MEM 3=WB
        int rd;     // 0 when the instruction writes no register
    } ent_t;

    ent_t q[$];
    int   m_state;  // 0 boot, 1 run, 2 drain, 3 halted
    int   m_cyc, m_ret, m_ctl, m_rdr;

    function automatic void m_decode(input logic [31:0] w, output int rd,
                                     output int rs1, output int rs2);
        logic [6:0] op;
        op  = w[6:0];
        rd  = 0;
        rs1 = 0;
        rs2 = 0;
        if (op == 7'h33) begin
            rd = int'(w[11:7]); rs1 = int'(w[19:15]); rs2 = int'(w[24:20]);
        end else if (op == 7'h13 || op == 7'h03 || op == 7'h67) begin
            rd = int'(w[11:7]); rs1 = int'(w[19:15]);
        end else if (op == 7'h23 || op == 7'h63) begin
            rs1 = int'(w[19:15]); rs2 = int'(w[24:20]);
        end else if (op == 7'h6f || op == 7'h37 || op == 7'h17) begin
            rd = int'(w[11:7]);
        end
    endfunction

    function automatic void m_advance();
        ent_t nq[$];
        foreach (q[i]) begin
            if (q[i].stage < 3) nq.push_back('{q[i].stage + 1, q[i].rd});
        end
        q = nq;
    endfunction

    function automatic void m_redirect();
        ent_t nq[$];
        foreach (q[i]) begin
            if (q[i].stage == 2) nq.push_back('{3, q[i].rd});
        end
        q = nq;
    endfunction

    task automatic model_cycle();
        logic [7:0] e_code;
        logic       e_insn, e_halt, haz, hlt, in_wb;
        int         rd, rs1, rs2;
        e_code = C_FREEZE;
        e_insn = 1'b0;
        e_halt = 1'b0;
        m_decode(id_instr, rd, rs1, rs2);
        haz = 1'b0;
        in_wb = 1'b0;
        foreach (q[i]) begin
            if (id_vld && q[i].rd != 0 && (q[i].rd == rs1 || q[i].rd == rs2)) haz = 1'b1;
            if (q[i].stage == 3) in_wb = 1'b1;
        end
        hlt = id_vld && (id_instr == HALT);
        if (rst) begin
            e_code = C_BOOT;
        end else if (m_state == 0) begin
            e_code = C_BOOT;
        end else if (m_state == 3) begin
            e_halt = 1'b1;
        end else begin
            e_insn = in_wb && !stall;
            if (stall) e_code = C_FREEZE;
            else if (redir) e_code = C_REDIR;
            else if (m_state == 2 || haz || hlt) e_code = C_HOLD;
            else e_code = C_NORM;
        end
        chk("rnd code", code, e_code);
        chk("rnd insn_vld", insn_vld, e_insn);
        chk("rnd halted", halted, e_halt);
        chk_cnt("rnd", m_cyc, m_ret, m_ctl, m_rdr);
        if (rst) begin
            m_state = 0;
            q.delete();
            m_cyc = 0; m_ret = 0; m_ctl = 0; m_rdr = 0;
        end else if (m_state == 0) begin
            q.delete();
            m_state = 1;
        end else if (m_state != 3) begin
            m_cyc++;
            if (e_insn) m_ret++;
            if (is_ctrl && !stall) m_ctl++;
            if (redir && !stall) m_rdr++;
            if (stall) begin
            end else if (redir) begin
                m_redirect();
                m_state = 1;
            end else if (m_state == 2 || haz || hlt) begin
                m_advance();
                if (m_state == 1 && hlt && !haz) m_state = 2;
                else if (m_state == 2 && q.size() == 0) m_state = 3;
            end else begin
                m_advance();
                if (id_vld) q.push_back('{1, rd});
            end
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct packed {
        logic        vld;
        logic [31:0] instr;
        logic        redir;
        logic        ctrl;
        logic        stall;
        logic [7:0]  code;
        logic        insn;
    } vec_t;

    vec_t tbl[15];

    logic [6:0] ops[9];
    int halted_run;

    initial begin
        tbl[0]  = '{1'b1, ADDI_X1, 1'b0, 1'b0, 1'b0, C_NORM,  1'b0};
        tbl[1]  = '{1'b1, ADD_X2,  1'b0, 1'b0, 1'b0, C_HOLD,  1'b0};
        tbl[2]  = '{1'b1, ADD_X2,  1'b0, 1'b0, 1'b0, C_HOLD,  1'b0};
        tbl[3]  = '{1'b1, ADD_X2,  1'b0, 1'b0, 1'b0, C_HOLD,  1'b1};
        tbl[4]  = '{1'b1, ADD_X2,  1'b0, 1'b0, 1'b0, C_NORM,  1'b0};
        tbl[5]  = '{1'b0, NOP,     1'b0, 1'b0, 1'b0, C_NORM,  1'b0};
        tbl[6]  = '{1'b0, NOP,     1'b0, 1'b0, 1'b0, C_NORM,  1'b0};
        tbl[7]  = '{1'b0, NOP,     1'b0, 1'b0, 1'b0, C_NORM,  1'b1};
        tbl[8]  = '{1'b1, ADDI_X0, 1'b0, 1'b0, 1'b0, C_NORM,  1'b0};
        tbl[9]  = '{1'b1, ADD_X3,  1'b0, 1'b0, 1'b0, C_NORM,  1'b0};
        tbl[10] = '{1'b1, BEQ,     1'b0, 1'b0, 1'b0, C_NORM,  1'b0};
        tbl[11] = '{1'b1, NOP,     1'b0, 1'b0, 1'b0, C_NORM,  1'b1};
        tbl[12] = '{1'b1, NOP,     1'b1, 1'b1, 1'b0, C_REDIR, 1'b1};
        tbl[13] = '{1'b0, NOP,     1'b0, 1'b0, 1'b0, C_NORM,  1'b1};
        tbl[14] = '{1'b0, NOP,     1'b0, 1'b0, 1'b0, C_NORM,  1'b0};

        // reset values while reset is held
        set_in(1'b0, NOP, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("reset code", code, C_BOOT);
        chk("reset insn_vld", insn_vld, 1'b0);
        chk("reset halted", halted, 1'b0);
        do_reset();
        chk_cnt("after reset", 0, 0, 0, 0);

        // RAW stall, x0 non-dependency, taken branch
        for (int i = 0; i < 15; i++) begin
            set_in(tbl[i].vld, tbl[i].instr, tbl[i].redir, tbl[i].ctrl, tbl[i].stall);
            @(negedge clk);
            chk($sformatf("tbl[%0d] code", i), code, tbl[i].code);
            chk($sformatf("tbl[%0d] insn_vld", i), insn_vld, tbl[i].insn);
            step();
        end
        set_in(1'b0, NOP, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_cnt("tbl end", 15, 5, 1, 1);

        // redirect held through a 4-cycle memory stall
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, NOP, 1'b1, 1'b1, 1'b1);
            @(negedge clk);
            chk($sformatf("stall[%0d] code", i), code, C_FREEZE);
            step();
        end
        set_in(1'b0, NOP, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("deferred redirect code", code, C_REDIR);
        step();
        set_in(1'b0, NOP, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_cnt("stall redirect", 5, 0, 1, 1);

        // halt marker behind two ALU ops
        do_reset();
        set_in(1'b1, ADDI_X1, 1'b0, 1'b0, 1'b0);
        @(negedge clk); chk("halt c0 code", code, C_NORM); step();
        set_in(1'b1, ADDI_X2, 1'b0, 1'b0, 1'b0);
        @(negedge clk); chk("halt c1 code", code, C_NORM); step();
        set_in(1'b1, HALT, 1'b0, 1'b0, 1'b0);
        @(negedge clk); chk("halt detect code", code, C_HOLD); step();
        @(negedge clk);
        chk("drain1 code", code, C_HOLD);
        chk("drain1 insn_vld", insn_vld, 1'b1);
        chk("drain1 halted", halted, 1'b0);
        step();
        @(negedge clk);
        chk("drain2 code", code, C_HOLD);
        chk("drain2 insn_vld", insn_vld, 1'b1);
        step();
        @(negedge clk);
        chk("halted code", code, C_FREEZE);
        chk("halted flag", halted, 1'b1);
        chk("halted insn_vld", insn_vld, 1'b0);
        chk_cnt("halted", 5, 2, 0, 0);
        set_in(1'b1, HALT, 1'b1, 1'b1, 1'b0);
        step(); step(); step();
        @(negedge clk);
        chk("halted hold flag", halted, 1'b1);
        chk_cnt("halted frozen", 5, 2, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("reset from halted code", code, C_BOOT);
        chk("reset from halted flag", halted, 1'b0);
        step();
        @(negedge clk);
        chk_cnt("reset from halted", 0, 0, 0, 0);

        // wrong-path halt marker cancelled by a redirect
        do_reset();
        set_in(1'b1, HALT, 1'b0, 1'b0, 1'b0);
        @(negedge clk); chk("wp halt code", code, C_HOLD); step();
        set_in(1'b0, NOP, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("wp redirect code", code, C_REDIR);
        chk("wp redirect halted", halted, 1'b0);
        step();
        set_in(1'b1, NOP, 1'b0, 1'b0, 1'b0);
        @(negedge clk); chk("wp resume code", code, C_NORM); step();
        @(negedge clk); chk("wp resume2 code", code, C_NORM);
        chk("wp resume halted", halted, 1'b0);
        step();

        // randomized run against the reference model
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};
        do_reset();
        m_state = 1;
        q.delete();
        m_cyc = 0; m_ret = 0; m_ctl = 0; m_rdr = 0;
        halted_run = 0;
        for (int n = 0; n < 4000; n++) begin
            logic [31:0] w;
            w = $urandom;
            w[6:0]   = ops[$urandom_range(0, 8)];
            w[11:7]  = 5'($urandom_range(0, 3));
            w[19:15] = 5'($urandom_range(0, 3));
            w[24:20] = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) w = HALT;
            set_in(($urandom_range(0, 9) < 8), w, ($urandom_range(0, 11) == 0),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
            if (redir) is_ctrl = 1'b1;
            halted_run = (m_state == 3) ? halted_run + 1 : 0;
            rst = (halted_run > 4) || ($urandom_range(0, 499) == 0);
            @(negedge clk);
            model_cycle();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
